ofdm_interleaver_pp: RTL and testbench

//  Parametrised 802.11a block interleaver, successor to the fixed-BPSK interleaver. Runtime-selectable

---
 rtl/ofdm_interleaver_pp_pkg.sv | 46 ++++
 rtl/ofdm_interleaver_pp_if.sv | 30 +++
 rtl/ofdm_interleaver_pp_ilv_perm.sv | 45 ++++
 rtl/ofdm_interleaver_pp.sv | 108 ++++++++++
 tb/tb_ofdm_interleaver_pp.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_interleaver_pp_pkg.sv
// ============================================================================
// ofdm_interleaver_pp_pkg : mode encodings and per-mode lookups for the
//                           802.11a ping-pong block interleaver
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
package ofdm_interleaver_pp_pkg;

  localparam int unsigned N_CBPS_MAX_DEF = 288;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_QAM16 = 2'b10,
    MODE_QAM64 = 2'b11
  } mode_e;

  function automatic logic [9:0] n_cbps(input logic [1:0] m);
    case (mode_e'(m))
      MODE_BPSK:  return 10'd48;
      MODE_QPSK:  return 10'd96;
      MODE_QAM16: return 10'd192;
      default:    return 10'd288;
    endcase
  endfunction

  function automatic logic [2:0] n_bpsc(input logic [1:0] m);
    case (mode_e'(m))
      MODE_BPSK:  return 3'd1;
      MODE_QPSK:  return 3'd2;
      MODE_QAM16: return 3'd4;
      default:    return 3'd6;
    endcase
  endfunction

  function automatic logic [1:0] s_of(input logic [1:0] m);
    case (mode_e'(m))
      MODE_QAM16: return 2'd2;
      MODE_QAM64: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_interleaver_pp_if.sv
// ============================================================================
// ofdm_interleaver_pp_if : input beat stream and output symbol stream
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
interface ofdm_interleaver_pp_if #(
  parameter int unsigned IN_W       = 2,
  parameter int unsigned N_CBPS_MAX = 288
);
  logic [1:0]            mode;
  logic [IN_W-1:0]       in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CBPS_MAX-1:0] out_data;
  logic [1:0]            out_mode;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_mode, out_valid
  );

  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_mode, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/ofdm_interleaver_pp_ilv_perm.sv
// ============================================================================
// ofdm_interleaver_pp_ilv_perm : combinational input index k -> output index j
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module ofdm_interleaver_pp_ilv_perm
  import ofdm_interleaver_pp_pkg::*;
(
  input  logic [8:0] k,
  input  logic [1:0] mode,
  output logic [8:0] j
);

  logic [9:0] n;
  logic [9:0] c;
  logic [9:0] i;
  logic [9:0] q;
  logic [9:0] t;

  // floor(16*i/N) is rewritten as i/(N/16) so every divisor is a per-mode constant
  always_comb begin
    n = n_cbps(mode);
    c = {4'd0, n[9:4]};
    i = (c * {6'd0, k[3:0]}) + {5'd0, k[8:4]};
    q = 10'd0;
    t = 10'd0;
    j = 9'(i);
    case (mode_e'(mode))
      MODE_QAM16: begin
        q = i / 10'd12;
        t = i + n - q;
        j = 9'({i[9:1], 1'b0} + {9'd0, t[0]});
      end
      MODE_QAM64: begin
        q = i / 10'd18;
        t = i + n - q;
        j = 9'(i - (i % 10'd3) + (t % 10'd3));
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ofdm_interleaver_pp.sv
// ============================================================================
// ofdm_interleaver_pp : runtime-mode 802.11a block interleaver, ping-pong banks
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module ofdm_interleaver_pp
  import ofdm_interleaver_pp_pkg::*;
#(
  parameter int unsigned IN_W       = 2,
  parameter int unsigned N_CBPS_MAX = N_CBPS_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ofdm_interleaver_pp_if.slave bus
);

  logic [1:0][N_CBPS_MAX-1:0] bank_q, bank_d;
  logic [1:0][1:0]            bank_mode_q, bank_mode_d;
  logic [1:0]                 full_q, full_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic [8:0]                 k_q, k_d;

  logic [1:0]                 cur_mode;
  logic [IN_W-1:0][8:0]       lane_j;
  logic                       wr_fire;
  logic                       rd_fire;
  logic                       last_beat;
  logic [9:0]                 rd_ncbps;

  // the first beat of a symbol permutes with the live mode, later beats with the latched one
  assign cur_mode  = (k_q == 9'd0) ? bus.mode : bank_mode_q[wr_bank_q];
  assign wr_fire   = bus.in_valid && bus.in_ready;
  assign rd_fire   = full_q[rd_bank_q] && bus.out_ready;
  assign last_beat = (({1'b0, k_q} + 10'(IN_W)) == n_cbps(cur_mode));

  generate
    for (genvar n = 0; n < IN_W; n++) begin : g_lane
      ofdm_interleaver_pp_ilv_perm u_perm (
        .k    (k_q + 9'(n)),
        .mode (cur_mode),
        .j    (lane_j[n])
      );
    end
  endgenerate

  always_comb begin
    bank_d      = bank_q;
    bank_mode_d = bank_mode_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    k_d         = k_q;
    if (wr_fire) begin
      for (int n = 0; n < IN_W; n++) begin
        bank_d[wr_bank_q][lane_j[n]] = bus.in_data[n];
      end
      if (k_q == 9'd0) begin
        bank_mode_d[wr_bank_q] = bus.mode;
      end
      if (last_beat) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        k_d               = 9'd0;
      end else begin
        k_d = k_q + 9'(IN_W);
      end
    end
    if (rd_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= '0;
      bank_mode_q <= '0;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      k_q         <= 9'd0;
    end else begin
      bank_q      <= bank_d;
      bank_mode_q <= bank_mode_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      k_q         <= k_d;
    end
  end

  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.out_mode  = bank_mode_q[rd_bank_q];
  assign rd_ncbps      = n_cbps(bank_mode_q[rd_bank_q]);

  // bits above N_CBPS may still hold a previous, larger symbol
  always_comb begin
    bus.out_data = '0;
    for (int b = 0; b < N_CBPS_MAX; b++) begin
      bus.out_data[b] = bank_q[rd_bank_q][b] && (10'(b) < rd_ncbps);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_interleaver_pp.sv
// ============================================================================
// tb_ofdm_interleaver_pp : scoreboard bench for the ping-pong interleaver
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module tb_ofdm_interleaver_pp;

  localparam int unsigned IN_W = 2;
  localparam int unsigned NMAX = 288;

  typedef struct {
    logic [NMAX-1:0] data;
    logic [1:0]      mode;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ofdm_interleaver_pp_if #(.IN_W(IN_W), .N_CBPS_MAX(NMAX)) bus ();

  ofdm_interleaver_pp #(.IN_W(IN_W), .N_CBPS_MAX(NMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   rx_cnt  = 0;
  logic rand_on = 1'b0;

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ncbps_of(input logic [1:0] m);
    case (m)
      2'b00:   return 48;
      2'b01:   return 96;
      2'b10:   return 192;
      default: return 288;
    endcase
  endfunction

  // reference permutation written straight from the 802.11a formulas
  function automatic logic [NMAX-1:0] interleave(input logic [1:0] m, input logic [NMAX-1:0] bits);
    int n    = ncbps_of(m);
    int bpsc = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 6;
    int s    = (bpsc / 2 > 1) ? bpsc / 2 : 1;
    logic [NMAX-1:0] r = '0;
    for (int k = 0; k < n; k++) begin
      int i  = (n / 16) * (k % 16) + k / 16;
      int jj = s * (i / s) + (i + n - (16 * i) / n) % s;
      r[jj] = bits[k];
    end
    return r;
  endfunction

  function automatic logic [NMAX-1:0] rand_vec();
    logic [NMAX-1:0] r;
    for (int w = 0; w < 9; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_sym(input logic [1:0] m, input logic [NMAX-1:0] bits,
                          input int beat_lim, output int stalls);
    int nb = ncbps_of(m) / IN_W;
    int beats;
    stalls = 0;
    beats  = (beat_lim < nb) ? beat_lim : nb;
    for (int b = 0; b < beats; b++) begin
      int wait_cyc = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = bits[b*IN_W +: IN_W];
      bus.mode     = (b == 0) ? m : 2'($urandom);
      @(negedge clk);
      while (!bus.in_ready && wait_cyc < 2000) begin
        stalls++;
        wait_cyc++;
        @(negedge clk);
      end
      if (!bus.in_ready) begin
        check("in_ready_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (beats == nb) exp_q.push_back('{data: interleave(m, bits), mode: m});
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_t e;
      check("sym_queued", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sym_data", bus.out_data, e.data);
        check("sym_mode", bus.out_mode, e.mode);
      end
      rx_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int st_sum;
    int r0;
    logic [NMAX-1:0] v;
    logic [NMAX-1:0] rv [3];
    logic [NMAX-1:0] ones48;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_mode", bus.out_mode, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // one-hot probes, known output positions
    v = '0; v[1] = 1'b1;
    send_sym(2'b00, v, 1000, st);
    check("bpsk_lat_valid", bus.out_valid, 1);
    check("bpsk_data", bus.out_data, 288'h8);
    check("bpsk_mode", bus.out_mode, 0);
    drain();
    v = '0; v[17] = 1'b1;
    send_sym(2'b01, v, 1000, st);
    check("qpsk_data", bus.out_data, 288'h80);
    check("qpsk_mode", bus.out_mode, 1);
    v = '0; v[1] = 1'b1;
    send_sym(2'b10, v, 1000, st);
    check("qam16_data", bus.out_data, 288'h2000);
    send_sym(2'b11, v, 1000, st);
    check("qam64_data", bus.out_data, 288'h100000);
    check("qam64_stalls", st, 0);
    drain();

    // backpressure: two symbols fill both banks, the third waits
    bus.out_ready = 1'b0;
    r0 = rx_cnt;
    for (int s = 0; s < 3; s++) rv[s] = rand_vec();
    send_sym(2'b00, rv[0], 1000, st);
    st_sum = st;
    send_sym(2'b00, rv[1], 1000, st);
    st_sum += st;
    check("bp_fill_stalls", st_sum, 0);
    check("bp_in_ready", bus.in_ready, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_ready", bus.in_ready, 0);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_data", bus.out_data, interleave(2'b00, rv[0]));
    end
    fork
      send_sym(2'b00, rv[2], 1000, st);
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_rx_cnt", rx_cnt - r0, 3);

    // stale upper bits from 64-QAM symbols must be masked off a BPSK symbol
    send_sym(2'b11, '1, 1000, st);
    send_sym(2'b11, '1, 1000, st);
    drain();
    ones48 = '0;
    ones48[47:0] = '1;
    send_sym(2'b00, '1, 1000, st);
    check("stale_mask", bus.out_data, ones48);
    drain();

    // back-to-back mixed modes with a free sink never stall
    st_sum = 0;
    for (int s = 0; s < 6; s++) begin
      send_sym(2'(s % 4), rand_vec(), 1000, st);
      st_sum += st;
    end
    check("no_bubble", st_sum, 0);
    drain();

    // random sink backpressure
    rand_on = 1'b1;
    fork
      begin
        for (int s = 0; s < 6; s++) send_sym(2'($urandom), rand_vec(), 1000, st);
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset with one stored symbol and a partial one in flight
    bus.out_ready = 1'b0;
    send_sym(2'b01, rand_vec(), 1000, st);
    send_sym(2'b11, rand_vec(), 10, st);
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_data", bus.out_data, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_sym(2'b10, rand_vec(), 1000, st);
    check("post_rst_valid", bus.out_valid, 1);
    drain();

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
